frame_fill_scheduler: RTL and testbench

Sequences and arbitrates frame-data fills from the shared 32-bit word source into the two display buffer banks of the display adapter. Each bank raises a refill request. The scheduler grants one bank at a time in round-robin order, drives exactly FRAME_WORDS writes with addresses to that bank, then signals completion. It sits between the word source and the bank write ports, and replaces direct free-running WE0/WE1 driving.

---
 rtl/frame_fill_scheduler.sv | 120 ++++++++++++
 tb/tb_frame_fill_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_fill_scheduler.sv
// Round-robin fill scheduler: grants one display bank at a time and streams
// FRAME_WORDS source words into it as registered bank writes, then pulses done.
module frame_fill_scheduler #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned FRAME_WORDS = 400,
    parameter int unsigned ADDR_W      = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic              WE0,
    output logic              WE1,
    output logic [ADDR_W-1:0] WAddr,
    output logic [DATA_W-1:0] WData,
    output logic              done0,
    output logic              done1,
    output logic              busy,
    output logic              grant_id
);

    typedef enum logic [1:0] {IDLE, GRANT, XFER, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                we0_d, we1_d, done0_d, done1_d, busy_d, grant_d;
    logic [ADDR_W-1:0]   waddr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic                pick;

    // State, counter and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            WE0          <= 1'b0;
            WE1          <= 1'b0;
            WAddr        <= '0;
            WData        <= '0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            busy         <= 1'b0;
            grant_id     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            WE0          <= we0_d;
            WE1          <= we1_d;
            WAddr        <= waddr_d;
            WData        <= wdata_d;
            done0        <= done0_d;
            done1        <= done1_d;
            busy         <= busy_d;
            grant_id     <= grant_d;
        end
    end

    // Arbitration, beat acceptance and next-output computation
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        we0_d        = 1'b0;
        we1_d        = 1'b0;
        waddr_d      = WAddr;
        wdata_d      = WData;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        busy_d       = busy;
        grant_d      = grant_id;
        src_ready    = 1'b0;
        pick         = (req0 && req1) ? ~last_grant_q : req1;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    busy_d       = 1'b1;
                    state_d      = GRANT;
                end
            end
            GRANT: begin
                cnt_d   = '0;
                state_d = XFER;
            end
            XFER: begin
                src_ready = 1'b1;
                if (src_valid) begin
                    we0_d   = ~grant_id;
                    we1_d   = grant_id;
                    waddr_d = cnt_q;
                    wdata_d = src_data;
                    // The last beat's done pulse lands together with its write
                    if (cnt_q == LAST_ADDR) begin
                        done0_d = ~grant_id;
                        done1_d = grant_id;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_frame_fill_scheduler.sv
// Bench for frame_fill_scheduler: arbitration table, directed fill scenarios and
// random traffic, all checked cycle by cycle against a fill-level reference model.
module tb_frame_fill_scheduler;

    localparam int unsigned DW = 32;
    localparam int unsigned FW = 400;
    localparam int unsigned AW = 9;
    localparam int N  = 16384;
    localparam int VW = 7 + AW + DW;

    logic          clock, reset, req0, req1, src_valid;
    logic [DW-1:0] src_data;
    logic          src_ready, WE0, WE1, done0, done1, busy, grant_id;
    logic [AW-1:0] WAddr;
    logic [DW-1:0] WData;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // per-cycle log of driven inputs and observed outputs
    bit            l_r0[N], l_r1[N], l_v[N];
    logic [DW-1:0] l_d[N];
    bit            o_we0[N], o_we1[N], o_d0[N], o_d1[N], o_busy[N], o_gid[N], o_rdy[N];
    logic [AW-1:0] o_addr[N];
    logic [DW-1:0] o_data[N];

    // model expectations
    bit            e_wf[N], e_wb[N], e_gf[N], e_gv[N], e_dn[N], e_busy[N], e_rdy[N];
    logic [AW-1:0] e_wa[N];
    logic [DW-1:0] e_wd[N];

    typedef struct {
        bit r0;
        bit r1;
        bit busy;
        bit gid;
        bit rdy;
    } vec_t;

    frame_fill_scheduler #(.DATA_W(DW), .FRAME_WORDS(FW), .ADDR_W(AW)) dut (
        .clock(clock), .reset(reset), .req0(req0), .req1(req1),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .WE0(WE0), .WE1(WE1), .WAddr(WAddr), .WData(WData),
        .done0(done0), .done1(done1), .busy(busy), .grant_id(grant_id)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    always @(negedge clock) begin
        if (cyc < N) begin
            l_r0[cyc] = req0;  l_r1[cyc] = req1;  l_v[cyc] = src_valid;  l_d[cyc] = src_data;
            o_we0[cyc] = WE0;  o_we1[cyc] = WE1;  o_d0[cyc] = done0;  o_d1[cyc] = done1;
            o_busy[cyc] = busy; o_gid[cyc] = grant_id; o_rdy[cyc] = src_ready;
            o_addr[cyc] = WAddr; o_data[cyc] = WData;
        end
        cyc++;
    end

    function automatic logic [VW-1:0] live();
        return {WE0, WE1, done0, done1, busy, grant_id, src_ready, WAddr, WData};
    endfunction

    task automatic chk(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int mode, input int k);
        case (mode)
            0: begin req0 = 0; req1 = 0; src_valid = 1; src_data = $urandom; end
            1: begin req0 = (k < 5); req1 = 0; src_valid = 1; src_data = 32'(k + 254); end
            2: begin req0 = 1; req1 = 1; src_valid = 1; src_data = $urandom; end
            3: begin req0 = 0; req1 = (k < 5); src_valid = ((k % 2) == 1); src_data = $urandom; end
            4: begin req0 = 0; req1 = (k < 13); src_valid = 1; src_data = $urandom; end
            5: begin
                req0 = ($urandom_range(0, 3) == 0);
                req1 = ($urandom_range(0, 4) == 0);
                src_valid = ($urandom_range(0, 3) != 0);
                src_data = $urandom;
            end
            default: begin req0 = 1; req1 = 0; src_valid = 1; src_data = $urandom; end
        endcase
    endtask

    task automatic run_seg(input int mode, input int len);
        for (int k = 0; k < len; k++) begin
            drive(mode, k);
            tick();
        end
    endtask

    task automatic do_reset();
        reset = 1; req0 = 0; req1 = 0; src_valid = 0; src_data = '0;
        tick();
        tick();
        chk("reset_outputs", longint'(live()), 0);
        reset = 0;
    endtask

    // Fill-level model: each arbitration grants at t+1, consumes the first FW
    // valid cycles from t+2, writes one cycle after each beat, re-arbitrates
    // two cycles after the last beat. Segment starts straight out of reset.
    task automatic check_seg(input int s, input int e);
        int t, c, i, last;
        bit lg, g, gg;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [VW-1:0] gv, ev;
        for (int k = s; k < e; k++) begin
            e_wf[k] = 0; e_wb[k] = 0; e_gf[k] = 0; e_gv[k] = 0;
            e_dn[k] = 0; e_busy[k] = 0; e_rdy[k] = 0; e_wa[k] = '0; e_wd[k] = '0;
        end
        lg = 1;
        t  = s;
        while (t < e) begin
            if (l_r0[t] || l_r1[t]) begin
                g  = (l_r0[t] && l_r1[t]) ? !lg : l_r1[t];
                lg = g;
                if (t + 1 < e) begin e_gf[t+1] = 1; e_gv[t+1] = g; end
                i = 0; c = t + 2; last = -1;
                while (i < int'(FW) && c < e) begin
                    if (l_v[c]) begin
                        if (c + 1 < e) begin
                            e_wf[c+1] = 1; e_wb[c+1] = g; e_wa[c+1] = AW'(i); e_wd[c+1] = l_d[c];
                        end
                        i++;
                        if (i == int'(FW)) last = c;
                    end
                    c++;
                end
                if (last < 0) begin
                    for (int k = t + 1; k < e; k++) begin
                        e_busy[k] = 1;
                        if (k >= t + 2) e_rdy[k] = 1;
                    end
                    t = e;
                end else begin
                    for (int k = t + 1; k <= last + 1 && k < e; k++) begin
                        e_busy[k] = 1;
                        if (k >= t + 2 && k <= last) e_rdy[k] = 1;
                    end
                    if (last + 1 < e) e_dn[last+1] = 1;
                    t = last + 2;
                end
            end else begin
                t++;
            end
        end
        a = '0; d = '0; gg = 0;
        for (int k = s; k < e; k++) begin
            if (e_wf[k]) begin a = e_wa[k]; d = e_wd[k]; end
            if (e_gf[k]) gg = e_gv[k];
            ev = {e_wf[k] && !e_wb[k], e_wf[k] && e_wb[k], e_dn[k] && !gg, e_dn[k] && gg,
                  e_busy[k], gg, e_rdy[k], a, d};
            gv = {o_we0[k], o_we1[k], o_d0[k], o_d1[k], o_busy[k], o_gid[k], o_rdy[k],
                  o_addr[k], o_data[k]};
            total++;
            if (gv !== ev) begin
                bad++;
                $display("FAIL trace cyc=%0d got=%h exp=%h", k - s, gv, ev);
            end
        end
    endtask

    function automatic int find_done(input bit bank, input int from, input int to);
        for (int c = from; c < to; c++)
            if (bank ? o_d1[c] : o_d0[c]) return c;
        return -1;
    endfunction

    function automatic int next_write(input int from, input int to);
        for (int c = from; c < to; c++)
            if (o_we0[c] || o_we1[c]) return c;
        return -1;
    endfunction

    initial begin
        vec_t tbl[4];
        int s, e, n, n0, n1, dc, nw, idx;
        int dcs[$];
        bit dids[$];

        reset = 1; req0 = 0; req1 = 0; src_valid = 0; src_data = '0;

        // arbitration table: {req0, req1, busy@GRANT, grant_id@GRANT, src_ready@XFER}
        tbl[0] = '{0, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 1, 0, 1};
        tbl[2] = '{0, 1, 1, 1, 1};
        tbl[3] = '{1, 1, 1, 0, 1};
        for (int i = 0; i < 4; i++) begin
            do_reset();
            req0 = tbl[i].r0; req1 = tbl[i].r1; src_valid = 1; src_data = $urandom;
            tick();
            req0 = 0; req1 = 0;
            chk($sformatf("tbl%0d_busy", i), longint'(busy), longint'(tbl[i].busy));
            chk($sformatf("tbl%0d_gid", i), longint'(grant_id), longint'(tbl[i].gid));
            chk($sformatf("tbl%0d_grant_rdy", i), longint'(src_ready), 0);
            tick();
            chk($sformatf("tbl%0d_xfer_rdy", i), longint'(src_ready), longint'(tbl[i].rdy));
        end

        // idle quiet
        do_reset(); s = cyc; run_seg(0, 1000); e = cyc;
        check_seg(s, e);
        n = 0;
        for (int c = s; c < e; c++)
            n += int'(o_rdy[c] | o_we0[c] | o_we1[c] | o_d0[c] | o_d1[c] | o_busy[c]);
        chk("idle_quiet", n, 0);

        // single bank 0 fill with data = addr + 0x100
        do_reset(); s = cyc; run_seg(1, 450); e = cyc;
        check_seg(s, e);
        n0 = 0; n1 = 0; n = 0;
        for (int c = s; c < e; c++) begin
            n0 += int'(o_we0[c]); n1 += int'(o_we1[c]);
            if (o_we0[c] && o_data[c] != 32'(o_addr[c]) + 32'h100) n++;
        end
        chk("single_we0_count", n0, 400);
        chk("single_we1_count", n1, 0);
        chk("single_data_bad", n, 0);
        dc = find_done(0, s, e);
        chk("single_done_cycle", dc - s, 402);
        if (dc >= 0 && dc + 1 < e) begin
            chk("single_done_addr", longint'(o_addr[dc]), 399);
            chk("single_done_we0", longint'(o_we0[dc]), 1);
            chk("single_busy_after", longint'(o_busy[dc+1]), 0);
        end

        // contention, both held
        do_reset(); s = cyc; run_seg(2, 1700); e = cyc;
        check_seg(s, e);
        dcs.delete(); dids.delete();
        for (int c = s; c < e; c++) begin
            if (o_d0[c]) begin dcs.push_back(c); dids.push_back(0); end
            if (o_d1[c]) begin dcs.push_back(c); dids.push_back(1); end
        end
        chk("cont_done_count", dcs.size(), 4);
        for (int i = 0; i < 4 && i < dcs.size(); i++) begin
            chk($sformatf("cont_order%0d", i), longint'(dids[i]), i % 2);
            n = 0;
            for (int c = (i == 0 ? s : dcs[i-1] + 1); c <= dcs[i]; c++)
                n += int'(o_we0[c] | o_we1[c]);
            chk($sformatf("cont_writes%0d", i), n, 400);
            if (i < 3) begin
                nw = next_write(dcs[i] + 1, e);
                chk($sformatf("cont_gap%0d", i), nw - dcs[i], 4);
            end
        end

        // bank 1 fill with source stalling every other cycle
        do_reset(); s = cyc; run_seg(3, 850); e = cyc;
        check_seg(s, e);
        n0 = 0; n1 = 0; n = 0; idx = 0; nw = 0;
        for (int c = s; c < e; c++) begin
            n0 += int'(o_we0[c]); n1 += int'(o_we1[c]); n += int'(o_rdy[c]);
            if (o_we1[c]) begin
                if (o_addr[c] != AW'(idx)) nw++;
                if (!l_v[c-1]) nw++;
                idx++;
            end
        end
        chk("stall_we1_count", n1, 400);
        chk("stall_we0_count", n0, 0);
        chk("stall_xfer_len", n, 800);
        chk("stall_order_bad", nw, 0);
        chk("stall_done_cycle", find_done(1, s, e) - s, 802);

        // request dropped at word 10
        do_reset(); s = cyc; run_seg(4, 460); e = cyc;
        check_seg(s, e);
        dc = find_done(1, s, e);
        chk("drop_done_cycle", dc - s, 402);
        if (dc >= 0) begin
            chk("drop_done_addr", longint'(o_addr[dc]), 399);
            n = 0;
            for (int c = dc + 1; c < e; c++) n += int'(o_busy[c] | o_we0[c] | o_we1[c]);
            chk("drop_no_regrant", n, 0);
        end

        // asynchronous reset at word 200 of a bank 0 fill
        do_reset(); s = cyc; run_seg(7, 203); e = cyc;
        check_seg(s, e);
        chk("rst_pre_addr", longint'(WAddr), 200);
        chk("rst_pre_busy", longint'(busy), 1);
        #2 reset = 1;
        #1 chk("rst_async_outputs", longint'(live()), 0);
        tick();
        reset = 0;
        s = cyc; run_seg(2, 900); e = cyc;
        check_seg(s, e);
        nw = next_write(s, e);
        if (nw >= 0)
            chk("rst_first_write", longint'({o_we0[nw], o_we1[nw], o_addr[nw]}), longint'({2'b10, AW'(0)}));
        else
            chk("rst_first_write_found", 0, 1);

        // random traffic
        do_reset(); s = cyc; run_seg(5, 3000); e = cyc;
        check_seg(s, e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
